// File: rtl/jk_seq_pkg.sv
// Shared opcodes and FSM state encoding for the JK command sequencer.
package jk_seq_pkg;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_TOGGLE = 2'b10;
    localparam logic [1:0] OP_COUNT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_APPLY = 2'b01,
        ST_COUNT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with enable and asynchronous active-high clear.
module jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic En,
    input  logic J,
    input  logic K,
    output logic Q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q <= 1'b0;
        end else if (En) begin
            case ({J, K})
                2'b10:   Q <= 1'b1;
                2'b01:   Q <= 1'b0;
                2'b11:   Q <= ~Q;
                default: Q <= Q;
            endcase
        end
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Command sequencer driving a bank of WIDTH JK cells (load/clear/toggle/count).
// Optional wrap pulse output enabled by defining JK_SEQ_WRAP_FLAG_EN.
module jk_cmd_sequencer
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
`ifdef JK_SEQ_WRAP_FLAG_EN
    ,
    output logic             wrap
`endif
);

    state_t           state, state_nxt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] remaining, remaining_nxt;
    logic [WIDTH-1:0] en, j, k;
    logic [WIDTH-1:0] inc_t;
    logic             accept;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign accept    = cmd_valid && cmd_ready;

    // Ripple-carry toggle terms: bit i flips when all lower bits are one.
    assign inc_t[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_inc
        assign inc_t[i] = &q[i-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
        end
    end

    // Command payload needs no reset: it is only consumed after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        en            = '0;
        j             = '0;
        k             = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_op != OP_COUNT) begin
                        state_nxt = ST_APPLY;
                    end else if (cmd_data == '0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt     = ST_COUNT;
                        remaining_nxt = cmd_data;
                    end
                end
            end
            ST_APPLY: begin
                en = '1;
                case (op_q)
                    OP_LOAD: begin
                        j = data_q;
                        k = ~data_q;
                    end
                    OP_CLEAR: k = '1;
                    OP_TOGGLE: begin
                        j = data_q;
                        k = data_q;
                    end
                    default: ;
                endcase
                state_nxt = ST_DONE;
            end
            ST_COUNT: begin
                en            = '1;
                j             = inc_t;
                k             = inc_t;
                remaining_nxt = remaining - WIDTH'(1);
                if (remaining == WIDTH'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .En    (en[i]),
            .J     (j[i]),
            .K     (k[i]),
            .Q     (q[i])
        );
    end

`ifdef JK_SEQ_WRAP_FLAG_EN
    // Flags the increment that rolls the bank over from all-ones to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap <= 1'b0;
        end else begin
            wrap <= (state == ST_COUNT) && (&q);
        end
    end
`endif

endmodule

// File: doc/jk_cmd_sequencer.md
JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

Interface
REQ-001 Parameter: WIDTH, default 4, number of JK cells in the controlled register bank.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: cmd_valid  input  1  command offered this cycle.
REQ-005 Port: cmd_ready  output  1  sequencer can accept a command this cycle.
REQ-006 Port: cmd_op  input  2  opcode: 00 LOAD, 01 CLEAR, 10 TOGGLE, 11 COUNT.
REQ-007 Port: cmd_data  input  WIDTH  LOAD value, TOGGLE mask, or COUNT step count N.
REQ-008 Port: q  output  WIDTH  current JK bank contents.
REQ-009 Port: busy  output  1  high whenever state is not IDLE.
REQ-010 Port: done  output  1  one-cycle pulse when a command completes.

Function
REQ-011 FSM states IDLE, APPLY, COUNT, DONE; cmd_ready SHALL equal (state==IDLE).
REQ-012 Command accepted on edge where cmd_valid && cmd_ready; op and data latched; cmd_data ignored otherwise.
REQ-013 IDLE: all cell enables low; q holds; cmd_valid low keeps IDLE.
REQ-014 LOAD/CLEAR/TOGGLE: IDLE -> APPLY; APPLY asserts all enables for one cycle, then -> DONE.
REQ-015 APPLY drive per bit i: LOAD J=data[i], K=~data[i]; CLEAR J=0, K=1; TOGGLE J=K=mask[i].
REQ-016 TOGGLE with mask 0 SHALL still take APPLY and DONE, q unchanged.
REQ-017 COUNT with N=0: IDLE -> DONE directly, q unchanged.
REQ-018 COUNT with N>0: IDLE -> COUNT; remaining=N; each COUNT cycle increments q by 1 via JK toggle logic (bit i J=K=AND of q[i-1:0], bit 0 J=K=1).
REQ-019 COUNT decrements remaining each cycle; on cycle with remaining==1 performs last increment and -> DONE; exactly N increments total.
REQ-020 Increment SHALL wrap modulo 2^WIDTH (all-ones -> 0) without stalling.
REQ-021 DONE: done=1 for exactly one cycle, enables low, -> IDLE.
REQ-022 Latency: LOAD accepted at edge k -> q valid after edge k+1, done high in cycle k+2, cmd_ready high again in cycle k+3.
REQ-023 COUNT N accepted at edge k -> q final after edge k+N, done high in cycle k+N+1.
REQ-024 Commands offered while busy SHALL not be accepted; requester holds cmd_valid until accepted.

Reset
REQ-025 reset high SHALL immediately, regardless of clk: q=0, state=IDLE, remaining=0, busy=0, done=0, cmd_ready=1.
REQ-026 reset mid-command aborts it; no done pulse is produced for the aborted command.
REQ-027 First command accepted on first rising edge after reset deasserts with cmd_valid high.

Configuration
REQ-028 Macro JK_SEQ_WRAP_FLAG_EN: when defined, add output wrap (1 bit), pulsing high one cycle in the cycle after a COUNT increment takes q from all-ones to 0; reset value 0.
REQ-029 Without JK_SEQ_WRAP_FLAG_EN: no wrap port; wrap-around behaviour of q is otherwise identical.

Structure
REQ-030 Shared package jk_seq_pkg SHALL hold opcode constants (OP_LOAD, OP_CLEAR, OP_TOGGLE, OP_COUNT) and state encodings.
REQ-031 Sub-module jk_cell: one JK flip-flop with clk, reset, En, J, K, Q; async active-high reset to 0; En low holds; JK 00 hold, 10 set, 01 clear, 11 toggle.
REQ-032 jk_cmd_sequencer instantiates WIDTH jk_cell instances; q is their concatenated Q; FSM only drives En/J/K.

Verification
REQ-033 Reset asserted mid-cycle with q=1010 -> q=0000, cmd_ready=1 without waiting for clk.
REQ-034 LOAD 1011 -> q=1011 after APPLY, single done pulse, cmd_ready back to 1 three cycles after acceptance.
REQ-035 LOAD 0110, TOGGLE 0101 -> q=0011; CLEAR -> q=0000; TOGGLE 0000 -> q unchanged, done still pulses.
REQ-036 LOAD 1110, COUNT 3 -> q sequence 1111, 0000, 0001; done after third increment; wrap pulses once when JK_SEQ_WRAP_FLAG_EN.
REQ-037 COUNT 0 -> q unchanged, done in cycle after acceptance; cmd_valid held during COUNT 5 -> second command accepted only after done.
REQ-038 Reset asserted during COUNT 9 after 4 increments -> q=0000, no done pulse, IDLE.
